// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first A-B over WIDTH shift cycles, with the
// registered difference and final borrow published on a one-cycle Done pulse.
//
// state | meaning
// IDLE  | waiting for Start; outputs hold the last result
// SHIFT | one bit pair per cycle through the cascaded half-subtractors
// DONE  | publish result, pulse Done, return to IDLE
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Minuend,
    input  logic [WIDTH-1:0] Subtrahend,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, a_sr_n;
    logic [WIDTH-1:0] b_sr, b_sr_n;
    logic [WIDTH-1:0] r_sr, r_sr_n;
    logic             bor, bor_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] diff_n;
    logic             borrow_n;
    logic             done_n;
    logic             d_bit, bout_bit;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            Difference <= '0;
            Borrow     <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_n;
            a_sr       <= a_sr_n;
            b_sr       <= b_sr_n;
            r_sr       <= r_sr_n;
            bor        <= bor_n;
            cnt        <= cnt_n;
            Difference <= diff_n;
            Borrow     <= borrow_n;
            Done       <= done_n;
        end
    end

    // Two cascaded half-subtractors on the current LSBs.
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
    assign bout_bit = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);

    always_comb begin
        state_n  = state;
        a_sr_n   = a_sr;
        b_sr_n   = b_sr;
        r_sr_n   = r_sr;
        bor_n    = bor;
        cnt_n    = cnt;
        diff_n   = Difference;
        borrow_n = Borrow;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    a_sr_n  = Minuend;
                    b_sr_n  = Subtrahend;
                    bor_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                r_sr_n = {d_bit, r_sr[WIDTH-1:1]};
                a_sr_n = a_sr >> 1;
                b_sr_n = b_sr >> 1;
                bor_n  = bout_bit;
                // Counter parks on the last index rather than wrapping.
                if (cnt == CNT_LAST) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                diff_n   = r_sr;
                borrow_n = bor;
                done_n   = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state == SHIFT) || (state == DONE);

endmodule
